// File: rtl/des_input_loader_if.sv
// Handshake and select bundle between the input loader and the
// selector / triple-DES core.
interface des_input_loader_if;
    logic [1:4] message_sw;
    logic [1:3] key1_sw;
    logic [1:3] key2_sw;
    logic       start_valid;
    logic       start_ready;
    logic       core_done;

    modport master (
        output message_sw,
        output key1_sw,
        output key2_sw,
        output start_valid,
        input  start_ready,
        input  core_done
    );

    modport slave (
        input  message_sw,
        input  key1_sw,
        input  key2_sw,
        input  start_valid,
        output start_ready,
        output core_done
    );
endinterface

// File: rtl/des_input_loader.sv
// Synchronises and debounces board switches/button, freezes the
// selection on a start press and requests a triple-DES run.
module des_input_loader #(
    parameter int DB_CYCLES = 1000000,
    parameter int CNT_W     = 20
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:4]                 message_sw_raw,
    input  logic [1:3]                 key1_sw_raw,
    input  logic [1:3]                 key2_sw_raw,
    input  logic                       start_btn_raw,
    des_input_loader_if.master         core_if,
    output logic                       busy,
    output logic                       overrun,
    output logic [1:0]                 state_dbg
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        REQ     = 2'd2,
        RUN     = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [10:0]      sync1_q;
    logic [10:0]      sync2_q;
    logic [1:10]      sw_vec;
    logic [1:10]      cand_sw_q;
    logic [1:10]      stable_sw_q;
    logic [CNT_W-1:0] cnt_sw_q;
    logic             cand_btn_q;
    logic             stable_btn_q;
    logic             prev_btn_q;
    logic [CNT_W-1:0] cnt_btn_q;
    logic             start_evt;

    state_e     state_q, state_d;
    logic [1:4] msg_q, msg_d;
    logic [1:3] k1_q, k1_d;
    logic [1:3] k2_q, k2_d;

    assign sw_vec    = sync2_q[10:1];
    assign start_evt = stable_btn_q & ~prev_btn_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            cand_sw_q    <= '0;
            stable_sw_q  <= '0;
            cnt_sw_q     <= '0;
            cand_btn_q   <= 1'b0;
            stable_btn_q <= 1'b0;
            prev_btn_q   <= 1'b0;
            cnt_btn_q    <= '0;
        end else begin
            sync1_q <= {message_sw_raw, key1_sw_raw,
                        key2_sw_raw, start_btn_raw};
            sync2_q <= sync1_q;
            // Stable only after DB_CYCLES consecutive equal samples
            if (sw_vec != cand_sw_q) begin
                cand_sw_q <= sw_vec;
                cnt_sw_q  <= '0;
            end else if (cnt_sw_q != CNT_MAX) begin
                cnt_sw_q <= cnt_sw_q + 1'b1;
            end
            if (cnt_sw_q == CNT_MAX)
                stable_sw_q <= cand_sw_q;
            if (sync2_q[0] != cand_btn_q) begin
                cand_btn_q <= sync2_q[0];
                cnt_btn_q  <= '0;
            end else if (cnt_btn_q != CNT_MAX) begin
                cnt_btn_q <= cnt_btn_q + 1'b1;
            end
            if (cnt_btn_q == CNT_MAX)
                stable_btn_q <= cand_btn_q;
            prev_btn_q <= stable_btn_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            msg_q   <= '0;
            k1_q    <= '0;
            k2_q    <= '0;
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
            k1_q    <= k1_d;
            k2_q    <= k2_d;
        end
    end

    always_comb begin
        state_d = state_q;
        msg_d   = msg_q;
        k1_d    = k1_q;
        k2_d    = k2_q;
        case (state_q)
            IDLE: begin
                if (start_evt)
                    state_d = CAPTURE;
            end
            CAPTURE: begin
                msg_d   = stable_sw_q[1:4];
                k1_d    = stable_sw_q[5:7];
                k2_d    = stable_sw_q[8:10];
                state_d = REQ;
            end
            REQ: begin
                if (core_if.start_ready)
                    state_d = RUN;
            end
            RUN: begin
                if (core_if.core_done)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign core_if.message_sw  = msg_q;
    assign core_if.key1_sw     = k1_q;
    assign core_if.key2_sw     = k2_q;
    assign core_if.start_valid = (state_q == REQ);
    assign busy                = (state_q != IDLE);
    assign overrun             = start_evt & (state_q != IDLE);
    assign state_dbg           = state_q;

endmodule

// File: tb/tb_des_input_loader.sv
// Directed bench for des_input_loader with DB_CYCLES=4: vector table
// of select patterns plus hand-written handshake/reset sequences.
module tb_des_input_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:4] msg_raw = '0;
    logic [1:3] k1_raw = '0;
    logic [1:3] k2_raw = '0;
    logic       btn_raw = 1'b0;
    logic       busy;
    logic       overrun;
    logic [1:0] state_dbg;

    int checks = 0;
    int errors = 0;

    des_input_loader_if bus();

    des_input_loader #(.DB_CYCLES(4), .CNT_W(3)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .message_sw_raw (msg_raw),
        .key1_sw_raw    (k1_raw),
        .key2_sw_raw    (k2_raw),
        .start_btn_raw  (btn_raw),
        .core_if        (bus),
        .busy           (busy),
        .overrun        (overrun),
        .state_dbg      (state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:4] msg;
        logic [1:3] k1;
        logic [1:3] k2;
        logic [1:4] exp_msg;
        logic [1:3] exp_k1;
        logic [1:3] exp_k2;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_sw(input logic [1:4] m, input logic [1:3] a,
                          input logic [1:3] b);
        msg_raw = m;
        k1_raw  = a;
        k2_raw  = b;
    endtask

    // Waits for start_valid; reports the state seen the cycle before.
    task automatic wait_valid(input string name, output logic [1:0] prev);
        logic [1:0] p;
        bit seen;
        p = 2'd0;
        seen = 0;
        prev = 2'd0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.start_valid) begin
                seen = 1;
                prev = p;
                break;
            end
            p = state_dbg;
        end
        chk({name, "_valid_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic pulse_done();
        bus.core_done = 1'b1;
        cyc(1);
        bus.core_done = 1'b0;
    endtask

    logic [1:0] prev_st;
    int         cnt;
    logic       bad;

    initial begin
        vecs[0] = '{4'b1010, 3'b011, 3'b110, 4'b1010, 3'b011, 3'b110};
        vecs[1] = '{4'b0101, 3'b100, 3'b001, 4'b0101, 3'b100, 3'b001};
        vecs[2] = '{4'b1000, 3'b100, 3'b001, 4'b1000, 3'b100, 3'b001};
        vecs[3] = '{4'b1111, 3'b111, 3'b111, 4'b1111, 3'b111, 3'b111};
        vecs[4] = '{4'b0000, 3'b000, 3'b000, 4'b0000, 3'b000, 3'b000};

        bus.start_ready = 1'b0;
        bus.core_done   = 1'b0;
        cyc(3);
        rst_n = 1'b1;

        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.message_sw != 0 || bus.key1_sw != 0 ||
                bus.key2_sw != 0 || bus.start_valid || busy ||
                overrun || state_dbg != 0)
                bad = 1;
        end
        chk("reset_quiet", 32'(bad), 32'd0);

        bus.start_ready = 1'b1;
        for (int v = 0; v < 5; v++) begin
            set_sw(vecs[v].msg, vecs[v].k1, vecs[v].k2);
            cyc(10);
            btn_raw = 1'b1;
            wait_valid("vec", prev_st);
            chk("vec_prev_capture", 32'(prev_st), 32'd1);
            chk("vec_msg", 32'(bus.message_sw), 32'(vecs[v].exp_msg));
            chk("vec_key1", 32'(bus.key1_sw), 32'(vecs[v].exp_k1));
            chk("vec_key2", 32'(bus.key2_sw), 32'(vecs[v].exp_k2));
            cnt = 1;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (bus.start_valid) cnt++;
            end
            chk("vec_valid_width", 32'(cnt), 32'd1);
            chk("vec_run_state", 32'(state_dbg), 32'd3);
            chk("vec_busy_run", 32'(busy), 32'd1);
            btn_raw = 1'b0;
            cyc(10);
            chk("vec_busy_hold", 32'(busy), 32'd1);
            pulse_done();
            chk("vec_idle_state", 32'(state_dbg), 32'd0);
            chk("vec_idle_busy", 32'(busy), 32'd0);
        end

        btn_raw = 1'b1;
        cyc(3);
        btn_raw = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.start_valid || state_dbg != 0) bad = 1;
        end
        chk("glitch_ignored", 32'(bad), 32'd0);

        bus.start_ready = 1'b0;
        set_sw(4'b0011, 3'b010, 3'b101);
        cyc(10);
        btn_raw = 1'b1;
        wait_valid("stall", prev_st);
        set_sw(4'b1111, 3'b111, 3'b111);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bus.start_valid || state_dbg != 2 ||
                bus.message_sw != 4'b0011 || bus.key1_sw != 3'b010 ||
                bus.key2_sw != 3'b101)
                bad = 1;
        end
        chk("stall_hold", 32'(bad), 32'd0);
        bus.start_ready = 1'b1;
        cyc(1);
        chk("stall_run", 32'(state_dbg), 32'd3);
        chk("stall_valid_drop", 32'(bus.start_valid), 32'd0);
        btn_raw = 1'b0;
        cyc(10);
        pulse_done();
        chk("stall_sel_kept",
            32'({bus.message_sw, bus.key1_sw, bus.key2_sw}),
            32'({4'b0011, 3'b010, 3'b101}));

        btn_raw = 1'b1;
        wait_valid("ovr", prev_st);
        cyc(1);
        chk("ovr_run", 32'(state_dbg), 32'd3);
        btn_raw = 1'b0;
        cyc(10);
        btn_raw = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (overrun) cnt++;
        end
        chk("ovr_pulses", 32'(cnt), 32'd1);
        chk("ovr_still_run", 32'(state_dbg), 32'd3);
        btn_raw = 1'b0;
        cyc(10);
        pulse_done();
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.start_valid || state_dbg != 0) bad = 1;
        end
        chk("ovr_not_queued", 32'(bad), 32'd0);

        bus.start_ready = 1'b0;
        btn_raw = 1'b1;
        wait_valid("rst", prev_st);
        btn_raw = 1'b0;
        cyc(10);
        chk("rst_in_req", 32'(state_dbg), 32'd2);
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        chk("rst_outputs",
            32'({bus.message_sw, bus.key1_sw, bus.key2_sw,
                 bus.start_valid, busy, overrun, state_dbg}),
            32'd0);
        bus.start_ready = 1'b1;
        pulse_done();
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.start_valid || busy || state_dbg != 0) bad = 1;
        end
        chk("rst_done_ignored", 32'(bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/des_input_loader.md
Name: des_input_loader

Overview:
- Upstream stage of the switch-driven message/key selector in the FPGA triple-DES path.
- Conditions the raw board inputs: 4 message-select switches, two 3-bit key-select fields, and a start push-button. Conditioning is a 2-flop synchronise, then debounce.
- On a debounced start press, freezes the selection and drives it to the selector as stable select codes.
- Hands a start request to the triple-DES core over a valid/ready handshake, then waits for the core's done pulse before accepting another press.

Parameters:
- DB_CYCLES, 1000000, number of consecutive stable clocks before a synchronised input is accepted (10 ms at 100 MHz); must be >= 2.
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DB_CYCLES.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- message_sw_raw  input  [1:4]  raw message-select switches, asynchronous.
- key1_sw_raw  input  [1:3]  raw key1-select switches, asynchronous.
- key2_sw_raw  input  [1:3]  raw key2-select switches, asynchronous.
- start_btn_raw  input  1  raw start button, active-high, asynchronous.
- message_sw  output  [1:4]  latched message select, to selector.
- key1_sw  output  [1:3]  latched key1 select, to selector.
- key2_sw  output  [1:3]  latched key2 select, to selector.
- start_valid  output  1  start request to triple-DES core.
- start_ready  input  1  core accepts start.
- core_done  input  1  one-cycle pulse from core, run finished.
- busy  output  1  high in CAPTURE, REQ and RUN.
- overrun  output  1  one-cycle pulse: debounced press arrived while not IDLE.
- state_dbg  output  2  FSM encoding: IDLE=0, CAPTURE=1, REQ=2, RUN=3.

Behaviour:
- Reset: when rst_n is low at a clk edge, clear everything. This covers synchroniser flops, candidate/stable registers, counters, FSM (to IDLE), message_sw/key1_sw/key2_sw (all 0), start_valid, busy, overrun and state_dbg. Reset mid-run drops the request with no completion; a core_done arriving later is ignored in IDLE.
- Synchronise: 2 flops on all 11 raw bits.
- Switch debounce: the 10 synchronised switch bits are one vector.
  - If the vector differs from the candidate: candidate <= vector, counter <= 0.
  - Otherwise the counter increments, saturating at DB_CYCLES-1.
  - When the counter equals DB_CYCLES-1, stable_sw <= candidate.
- Button debounce: same scheme with its own counter, producing stable_btn.
- Start event: one-cycle pulse on the stable_btn 0->1 transition only. Holding the button produces no repeats.
- FSM:
  - IDLE: on a start event -> CAPTURE.
  - CAPTURE (1 cycle): load the outputs from stable_sw (bits 1:4 message, 5:7 key1, 8:10 key2) -> REQ.
  - REQ: start_valid=1. When start_ready=1 at a clk edge -> RUN, and start_valid drops that edge. start_valid must not drop before acceptance.
  - RUN: on core_done -> IDLE. A core_done seen in the same cycle as the REQ->RUN transition is ignored.
- Latency: start event in cycle N -> outputs updated at the N+1 edge, start_valid high from N+2.
- Select outputs change only in CAPTURE. Switch movement in any other state has no effect on them.
- A start event in CAPTURE, REQ or RUN is dropped and pulses overrun for 1 cycle. It is not queued.
- Minimum-width glitch: an input change shorter than DB_CYCLES clocks never reaches the stable registers.

Test Plan (DB_CYCLES=4):
1. Reset released, no activity -> all outputs 0, state_dbg=0 for 50 cycles.
2. Switches set to message 4'b1010, key1 3'b011, key2 3'b110, held 10 cycles, then button pressed and held 10 cycles; start_ready tied 1 -> message_sw=1010, key1_sw=011, key2_sw=110; start_valid high exactly 1 cycle; busy held until core_done pulsed, then state_dbg=0.
3. Button glitch high for 3 cycles -> no start_valid, state stays IDLE.
4. start_ready held 0 for 20 cycles after request -> start_valid stays 1 and selects are unchanged while switches toggle to 1111/111/111; start_ready raised -> RUN.
5. Second debounced press during RUN -> overrun pulses once, no second request after core_done.
6. rst_n low for 1 cycle while in REQ -> next cycle all outputs 0, state IDLE; a later core_done has no effect.
